vram_slot_arbiter: RTL and testbench

//  Time-slot arbiter for the single-port VDP VRAM (32K x 8, synchronous, 1-cycle read).

---
 rtl/vram_slot_arbiter.sv | 129 ++++++++++++
 tb/tb_vram_slot_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// rtl/vram_slot_arbiter.sv - time-slot arbiter sharing the single-port VDP VRAM
// Display owns the first DISP_SLOTS slots of each cell; CPU and fill round-robin the rest.
module vram_slot_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int SLOTS      = 8,
  parameter int DISP_SLOTS = 3,
  localparam int SLOT_W    = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [SLOT_W-1:0] slot,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [SLOT_W-1:0] disp_tag,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_wdata,
  output logic              fill_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {OP_NONE, OP_DISP, OP_CPU, OP_FILL} op_e;

  localparam logic [SLOT_W:0] DISP_N = (SLOT_W+1)'(DISP_SLOTS);

  op_e               pend_op;
  op_e               issue_op;
  logic              pend_rd;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] pend_slot;
  logic              rr_cpu;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              disp_slot;
  logic              cpu_elig;
  logic              fill_elig;

  assign disp_slot = disp_en && ({1'b0, slot_q} < DISP_N);

  // A request being acked this cycle is the one that already issued; skip it.
  assign cpu_elig  = cpu_req  && (pend_op != OP_CPU);
  assign fill_elig = fill_req && (pend_op != OP_FILL);

  always_comb begin
    issue_op = OP_NONE;
    if (reset)
      issue_op = OP_NONE;
    else if (disp_slot)
      issue_op = OP_DISP;
    else if (cpu_elig && fill_elig)
      issue_op = rr_cpu ? OP_CPU : OP_FILL;
    else if (cpu_elig)
      issue_op = OP_CPU;
    else if (fill_elig)
      issue_op = OP_FILL;
  end

  // Idle cycles keep the bus at its last value so the RAM sees no spurious change.
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    case (issue_op)
      OP_DISP: ram_addr = disp_addr;
      OP_CPU: begin
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
        if (cpu_we)
          ram_wdata = cpu_wdata;
      end
      OP_FILL: begin
        ram_addr  = fill_addr;
        ram_we    = 1'b1;
        ram_wdata = fill_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '0;
      pend_op   <= OP_NONE;
      pend_rd   <= 1'b0;
      pend_slot <= '0;
      rr_cpu    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      slot_q  <= slot_q + 1'b1;
      pend_op <= issue_op;
      pend_rd <= (issue_op == OP_CPU) && !cpu_we;
      if (issue_op == OP_DISP)
        pend_slot <= slot_q;
      if (issue_op == OP_CPU)
        rr_cpu <= 1'b0;
      else if (issue_op == OP_FILL)
        rr_cpu <= 1'b1;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
      if ((pend_op == OP_CPU) && pend_rd)
        rdata_q <= ram_rdata;
    end
  end

  // Completions are gated by reset so a discarded op never reports.
  assign slot       = slot_q;
  assign disp_valid = (pend_op == OP_DISP) && !reset;
  assign disp_tag   = pend_slot;
  assign disp_data  = disp_valid ? ram_rdata : '0;
  assign cpu_ack    = (pend_op == OP_CPU) && !reset;
  assign fill_ack   = (pend_op == OP_FILL) && !reset;
  assign cpu_rdata  = (cpu_ack && pend_rd) ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb/tb_vram_slot_arbiter.sv - self-checking bench for vram_slot_arbiter
// Includes a 32K x 8 synchronous RAM model with 1-cycle read.
module tb_vram_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  slot;
  logic        disp_en;
  logic [14:0] disp_addr;
  logic        disp_valid;
  logic [2:0]  disp_tag;
  logic [7:0]  disp_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        fill_req;
  logic [14:0] fill_addr;
  logic [7:0]  fill_wdata;
  logic        fill_ack;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  logic [7:0] mem [0:32767];

  int checks = 0;
  int errors = 0;

  vram_slot_arbiter dut (
    .clk(clk), .reset(reset), .slot(slot),
    .disp_en(disp_en), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .disp_tag(disp_tag), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_ack(fill_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        de;
    logic [14:0] da;
    logic        cr;
    logic        cw;
    logic [14:0] ca;
    logic [7:0]  cd;
    logic [2:0]  e_slot;
    logic        e_we;
    logic [14:0] e_addr;
    logic        e_ack;
    logic        e_dv;
    logic [2:0]  e_tag;
    logic [7:0]  e_dd;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic de, logic [14:0] da, logic cr, logic cw, logic [14:0] ca,
                              logic [7:0] cd, logic [2:0] es, logic ew, logic [14:0] ea,
                              logic ek, logic ev, logic [2:0] et, logic [7:0] ed, logic [7:0] er);
    vec_t v;
    v.de = de; v.da = da; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.e_slot = es; v.e_we = ew; v.e_addr = ea; v.e_ack = ek;
    v.e_dv = ev; v.e_tag = et; v.e_dd = ed; v.e_rd = er;
    return v;
  endfunction

  task automatic idle_inputs();
    disp_en = 0; disp_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fill_req = 0; fill_addr = '0; fill_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h0123] = 8'h5A;
    mem[15'h0040] = 8'h11;
    mem[15'h0041] = 8'h22;
    mem[15'h0042] = 8'h33;

    //         de da       cr cw ca       cd     slot we addr   ack dv tag dd     rd
    vecs[0]  = mk(1, 15'h0123, 0, 0, 15'h0000, 8'h00, 0, 0, 15'h0123, 0, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mk(1, 15'h0041, 1, 1, 15'h1000, 8'hA5, 1, 0, 15'h0041, 0, 1, 0, 8'h5A, 8'h00);
    vecs[2]  = mk(1, 15'h0042, 1, 1, 15'h1000, 8'hA5, 2, 0, 15'h0042, 0, 1, 1, 8'h22, 8'h00);
    vecs[3]  = mk(1, 15'h0000, 1, 1, 15'h1000, 8'hA5, 3, 1, 15'h1000, 0, 1, 2, 8'h33, 8'h00);
    vecs[4]  = mk(1, 15'h0000, 1, 1, 15'h1000, 8'hA5, 4, 0, 15'h1000, 1, 0, 0, 8'h00, 8'h00);
    vecs[5]  = mk(1, 15'h0000, 1, 0, 15'h1000, 8'h00, 5, 0, 15'h1000, 0, 0, 0, 8'h00, 8'h00);
    vecs[6]  = mk(1, 15'h0000, 1, 0, 15'h1000, 8'h00, 6, 0, 15'h1000, 1, 0, 0, 8'h00, 8'hA5);
    vecs[7]  = mk(1, 15'h0000, 0, 0, 15'h1000, 8'h00, 7, 0, 15'h1000, 0, 0, 0, 8'h00, 8'hA5);
    vecs[8]  = mk(1, 15'h0040, 1, 0, 15'h0123, 8'h00, 0, 0, 15'h0040, 0, 0, 0, 8'h00, 8'hA5);
    vecs[9]  = mk(1, 15'h0041, 1, 0, 15'h0123, 8'h00, 1, 0, 15'h0041, 0, 1, 0, 8'h11, 8'hA5);
    vecs[10] = mk(1, 15'h0042, 1, 0, 15'h0123, 8'h00, 2, 0, 15'h0042, 0, 1, 1, 8'h22, 8'hA5);
    vecs[11] = mk(1, 15'h0000, 1, 0, 15'h0123, 8'h00, 3, 0, 15'h0123, 0, 1, 2, 8'h33, 8'hA5);
    vecs[12] = mk(1, 15'h0000, 1, 0, 15'h0123, 8'h00, 4, 0, 15'h0123, 1, 0, 0, 8'h00, 8'h5A);
    vecs[13] = mk(0, 15'h0000, 0, 0, 15'h0000, 8'h00, 5, 0, 15'h0123, 0, 0, 0, 8'h00, 8'h5A);
    vecs[14] = mk(0, 15'h0000, 0, 0, 15'h0000, 8'h00, 6, 0, 15'h0123, 0, 0, 0, 8'h00, 8'h5A);
    vecs[15] = mk(0, 15'h0000, 0, 0, 15'h0000, 8'h00, 7, 0, 15'h0123, 0, 0, 0, 8'h00, 8'h5A);
    vecs[16] = mk(0, 15'h0000, 1, 0, 15'h0041, 8'h00, 0, 0, 15'h0041, 0, 0, 0, 8'h00, 8'h5A);
    vecs[17] = mk(0, 15'h0000, 1, 0, 15'h0041, 8'h00, 1, 0, 15'h0041, 1, 0, 0, 8'h00, 8'h22);

    // Reset values after holding reset several clocks
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_slot", slot, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_tag", disp_tag, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_fill_ack", fill_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Display fetch, CPU write/read, display-slot blocking, disp_en=0 access
    for (int i = 0; i < 18; i++) begin
      disp_en = vecs[i].de; disp_addr = vecs[i].da;
      cpu_req = vecs[i].cr; cpu_we = vecs[i].cw;
      cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      @(negedge clk);
      check($sformatf("v%0d_slot", i), slot, vecs[i].e_slot);
      check($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
      check($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      check($sformatf("v%0d_cpu_ack", i), cpu_ack, vecs[i].e_ack);
      check($sformatf("v%0d_fill_ack", i), fill_ack, 0);
      check($sformatf("v%0d_disp_valid", i), disp_valid, vecs[i].e_dv);
      check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
      if (vecs[i].e_dv) begin
        check($sformatf("v%0d_disp_tag", i), disp_tag, vecs[i].e_tag);
        check($sformatf("v%0d_disp_data", i), disp_data, vecs[i].e_dd);
      end
      @(posedge clk);
      #1;
    end

    // CPU and fill contending with display active: alternation, latency, data
    begin
      int cyc, cpu_start, fill_start, cpu_n, fill_n;
      logic last_fill;
      logic got_c, got_f;
      do_reset();
      disp_en = 1;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h3000; cpu_wdata = 8'h50;
      fill_req = 1; fill_addr = 15'h2000; fill_wdata = 8'hC0;
      cyc = 0; cpu_start = 0; fill_start = 0; cpu_n = 0; fill_n = 0;
      last_fill = 1'b1;
      for (int t = 0; t < 200 && fill_n < 8; t++) begin
        @(negedge clk);
        got_c = cpu_ack;
        got_f = fill_ack;
        if (slot < 3) check("t4_disp_slot_we", ram_we, 0);
        if (got_c) begin
          check("t4_alt_cpu", last_fill, 1);
          check("t4_cpu_latency_ok", (cyc - cpu_start) <= 6, 1);
          last_fill = 1'b0;
        end
        if (got_f) begin
          check("t4_alt_fill", last_fill, 0);
          check("t4_fill_latency_ok", (cyc - fill_start) <= 6, 1);
          last_fill = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (got_c) begin
          cpu_n++;
          cpu_addr = 15'h3000 + 15'(cpu_n);
          cpu_wdata = 8'h50 + 8'(cpu_n);
          cpu_start = cyc;
        end
        if (got_f) begin
          fill_n++;
          if (fill_n == 8) fill_req = 0;
          fill_addr = 15'h2000 + 15'(fill_n);
          fill_wdata = 8'hC0 + 8'(fill_n);
          fill_start = cyc;
        end
      end
      cpu_req = 0; fill_req = 0;
      check("t4_fill_count", fill_n, 8);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 8; i++)
        check($sformatf("t4_fill_mem%0d", i), mem[15'h2000 + 15'(i)], 8'hC0 + 8'(i));
      for (int j = 0; j < cpu_n; j++)
        check($sformatf("t4_cpu_mem%0d", j), mem[15'h3000 + 15'(j)], 8'h50 + 8'(j));
    end

    // disp_en=0: back-to-back CPU writes, one every 2 clks in any slot
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h5000; cpu_wdata = 8'h10;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      check($sformatf("t5_ack%0d", t), cpu_ack, (t % 2) == 1);
      check($sformatf("t5_we%0d", t), ram_we, (t % 2) == 0);
      @(posedge clk);
      #1;
      if ((t % 2) == 1) begin
        cpu_addr = cpu_addr + 15'd1;
        cpu_wdata = cpu_wdata + 8'd1;
      end
    end
    cpu_req = 0;
    @(posedge clk);
    #1;
    check("t5_mem_first", mem[15'h5000], 8'h10);
    check("t5_mem_last", mem[15'h5007], 8'h17);

    // Reset the clk after a CPU write issues: no ack, no write during reset
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h4000; cpu_wdata = 8'h77;
    @(negedge clk);
    check("t6_issue_we", ram_we, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t6_rst_ack", cpu_ack, 0);
    check("t6_rst_we", ram_we, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t6_rst_hold_we", ram_we, 0);
      check("t6_rst_hold_ack", cpu_ack, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cpu_req = 0;
    repeat (3) begin
      @(negedge clk);
      check("t6_post_ack", cpu_ack, 0);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
